idct_one_dimensional: RTL and testbench

8-point 1-D inverse DCT, the decode-side counterpart of the 1-D DCT stage. It accepts eight signed coefficients on one packed bus and produces eight signed spatial samples. It uses an even/odd (butterfly) decomposition with 8 parallel constant multipliers, evaluated over 4 cycles. Two instances with a transpose buffer form the 2-D IDCT for loopback and decode.

---
 rtl/idct_one_dimensional.sv | 159 +++++++++++++++
 tb/tb_idct_one_dimensional.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/idct_one_dimensional.sv
// 8-point 1-D inverse DCT: even/odd butterfly with 8 constant multipliers, one
// output pair per cycle over 4 cycles, results published atomically with data_en.
module idct_one_dimensional #(
  parameter int DW   = 12,
  parameter int CW   = 13,
  parameter int FRAC = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [8*DW-1:0]   IDCT_data_in,
  output logic              ready,
  output logic [DW-1:0]     IDCT_data_o_x0,
  output logic [DW-1:0]     IDCT_data_o_x1,
  output logic [DW-1:0]     IDCT_data_o_x2,
  output logic [DW-1:0]     IDCT_data_o_x3,
  output logic [DW-1:0]     IDCT_data_o_x4,
  output logic [DW-1:0]     IDCT_data_o_x5,
  output logic [DW-1:0]     IDCT_data_o_x6,
  output logic [DW-1:0]     IDCT_data_o_x7,
  output logic              data_en
);

  localparam int PW = DW + CW;   // product width
  localparam int SW = PW + 2;    // E/O sum width
  localparam int RW = SW + 1;    // E+-O width

  localparam logic signed [CW-1:0] C4   = CW'(1448);
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (DW - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (DW - 1)));
  localparam logic signed [RW-1:0] HALF = RW'(2 ** (FRAC - 1));

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                state;
  logic [1:0]            n;
  logic signed [DW-1:0]  coef     [8];
  logic signed [DW-1:0]  work_buf [8];
  logic signed [DW-1:0]  out_r    [8];

  logic signed [CW-1:0]  a2, a4, a6, b1, b3, b5, b7;
  logic signed [PW-1:0]  p0, p2, p4, p6, p1, p3, p5, p7;
  logic signed [SW-1:0]  e_sum, o_sum;
  logic signed [RW-1:0]  sum_pos, sum_neg;
  logic signed [DW-1:0]  x_pos, x_neg;
  logic [2:0]            lo_idx, hi_idx;

  function automatic logic signed [DW-1:0] round_sat(input logic signed [RW-1:0] v);
    logic signed [RW-1:0] r;
    r = (v + HALF) >>> FRAC;
    if (r > MAXV)      r = MAXV;
    else if (r < MINV) r = MINV;
    return r[DW-1:0];
  endfunction

  always_comb begin
    a2 = '0; a4 = '0; a6 = '0;
    b1 = '0; b3 = '0; b5 = '0; b7 = '0;
    case (n)
      2'd0: begin
        a2 = CW'(1892);  a4 = CW'(1448);  a6 = CW'(784);
        b1 = CW'(2009);  b3 = CW'(1703);  b5 = CW'(1138);  b7 = CW'(400);
      end
      2'd1: begin
        a2 = CW'(784);   a4 = CW'(-1448); a6 = CW'(-1892);
        b1 = CW'(1703);  b3 = CW'(-400);  b5 = CW'(-2009); b7 = CW'(-1138);
      end
      2'd2: begin
        a2 = CW'(-784);  a4 = CW'(-1448); a6 = CW'(1892);
        b1 = CW'(1138);  b3 = CW'(-2009); b5 = CW'(400);   b7 = CW'(1703);
      end
      2'd3: begin
        a2 = CW'(-1892); a4 = CW'(1448);  a6 = CW'(-784);
        b1 = CW'(400);   b3 = CW'(-1138); b5 = CW'(1703);  b7 = CW'(-2009);
      end
      default: ;
    endcase
  end

  always_comb begin
    p0 = PW'(coef[0]) * PW'(C4);
    p2 = PW'(coef[2]) * PW'(a2);
    p4 = PW'(coef[4]) * PW'(a4);
    p6 = PW'(coef[6]) * PW'(a6);
    p1 = PW'(coef[1]) * PW'(b1);
    p3 = PW'(coef[3]) * PW'(b3);
    p5 = PW'(coef[5]) * PW'(b5);
    p7 = PW'(coef[7]) * PW'(b7);
    e_sum   = SW'(p0) + SW'(p2) + SW'(p4) + SW'(p6);
    o_sum   = SW'(p1) + SW'(p3) + SW'(p5) + SW'(p7);
    sum_pos = RW'(e_sum) + RW'(o_sum);
    sum_neg = RW'(e_sum) - RW'(o_sum);
    x_pos   = round_sat(sum_pos);
    x_neg   = round_sat(sum_neg);
    lo_idx  = {1'b0, n};
    hi_idx  = 3'd7 - {1'b0, n};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      data_en <= 1'b0;
      n       <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        coef[i]     <= '0;
        work_buf[i] <= '0;
        out_r[i]    <= '0;
      end
    end else begin
      data_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned k = 0; k < 8; k++) coef[k] <= IDCT_data_in[DW*k +: DW];
            n     <= '0;
            ready <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          work_buf[lo_idx] <= x_pos;
          work_buf[hi_idx] <= x_neg;
          n                <= n + 2'd1;
          if (n == 2'd3) begin
            // Final pair bypasses the buffer so all eight outputs change together.
            for (int unsigned i = 0; i < 8; i++) out_r[i] <= work_buf[i];
            out_r[3] <= x_pos;
            out_r[4] <= x_neg;
            data_en  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign IDCT_data_o_x0 = out_r[0];
  assign IDCT_data_o_x1 = out_r[1];
  assign IDCT_data_o_x2 = out_r[2];
  assign IDCT_data_o_x3 = out_r[3];
  assign IDCT_data_o_x4 = out_r[4];
  assign IDCT_data_o_x5 = out_r[5];
  assign IDCT_data_o_x6 = out_r[6];
  assign IDCT_data_o_x7 = out_r[7];

endmodule

// File: tb/tb_idct_one_dimensional.sv
// Bench for idct_one_dimensional: directed table, multi-cycle corner sequences and
// random vectors against a direct-sum reference with cosine constants from $cos.
module tb_idct_one_dimensional;
  localparam int DW = 12;

  typedef int arr8_t [8];
  typedef struct {
    logic [8*DW-1:0] din;
    arr8_t           exp;
    logic [7:0]      mask;
  } vec_t;

  logic            sys_clk   = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            start     = 1'b0;
  logic [8*DW-1:0] din       = '0;
  logic            ready, data_en;
  logic [DW-1:0]   x0, x1, x2, x3, x4, x5, x6, x7;
  logic signed [DW-1:0] xo [8];

  int n_cmp = 0;
  int n_bad = 0;
  int cm [8][8];

  idct_one_dimensional #(.DW(12), .CW(13), .FRAC(12)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .start          (start),
    .IDCT_data_in   (din),
    .ready          (ready),
    .IDCT_data_o_x0 (x0),
    .IDCT_data_o_x1 (x1),
    .IDCT_data_o_x2 (x2),
    .IDCT_data_o_x3 (x3),
    .IDCT_data_o_x4 (x4),
    .IDCT_data_o_x5 (x5),
    .IDCT_data_o_x6 (x6),
    .IDCT_data_o_x7 (x7),
    .data_en        (data_en)
  );

  assign xo[0] = x0; assign xo[1] = x1; assign xo[2] = x2; assign xo[3] = x3;
  assign xo[4] = x4; assign xo[5] = x5; assign xo[6] = x6; assign xo[7] = x7;

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8*DW-1:0] pack8(input arr8_t v);
    logic [8*DW-1:0] r;
    int t;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      t = v[k];
      r[DW*k +: DW] = t[DW-1:0];
    end
    return r;
  endfunction

  // x[n] = sum_k X[k]*C[k][n], rounded half-up at 2^-12 then clamped to 12 bits.
  function automatic arr8_t model(input logic [8*DW-1:0] d);
    arr8_t  r;
    longint s;
    longint q;
    for (int n = 0; n < 8; n++) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += longint'($signed(d[DW*k +: DW])) * longint'(cm[k][n]);
      q = (s + 2048) >>> 12;
      if (q > 2047)  q = 2047;
      if (q < -2048) q = -2048;
      r[n] = int'(q);
    end
    return r;
  endfunction

  // Caller is just after a negedge; start is sampled at the next posedge (cycle 0).
  task automatic run_vec(input logic [8*DW-1:0] d, input arr8_t exp, input logic [7:0] mask,
                         input string tag);
    arr8_t ref_v;
    arr8_t cap;
    ref_v = model(d);
    start = 1'b1;
    din   = d;
    for (int c = 1; c <= 7; c++) begin
      @(negedge sys_clk);
      start = 1'b0;
      din   = {$urandom, $urandom, $urandom};
      chk({tag, " data_en"}, data_en, (c == 5));
      if (c <= 6) chk({tag, " ready"}, ready, (c == 6));
      if (c == 5) for (int i = 0; i < 8; i++) cap[i] = xo[i];
    end
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) chk($sformatf("%s x%0d table", tag, i), cap[i], exp[i]);
      chk($sformatf("%s x%0d model", tag, i), cap[i], ref_v[i]);
    end
  endtask

  vec_t  tbl [6];
  arr8_t v;
  arr8_t z;

  initial begin
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++)
        cm[k][n] = $rtoi($floor(4096.0 * ((k == 0) ? (1.0 / $sqrt(2.0)) : 1.0) / 2.0
                   * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0) + 0.5));

    z = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[0].din = pack8('{800, 0, 0, 0, 0, 0, 0, 0});
    tbl[0].exp = '{283, 283, 283, 283, 283, 283, 283, 283};   tbl[0].mask = 8'hFF;
    tbl[1].din = pack8('{0, 1000, 0, 0, 0, 0, 0, 0});
    tbl[1].exp = '{490, 416, 278, 98, -98, -278, -416, -490}; tbl[1].mask = 8'hFF;
    tbl[2].din = pack8('{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047});
    tbl[2].exp = '{2047, 0, 0, 0, 0, 0, 0, 0};                tbl[2].mask = 8'h01;
    tbl[3].din = pack8('{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048});
    tbl[3].exp = '{-2048, 0, 0, 0, 0, 0, 0, 0};               tbl[3].mask = 8'h01;
    tbl[4].din = pack8('{-400, 0, 0, 0, 0, 0, 0, 0});
    tbl[4].exp = '{-141, -141, -141, -141, -141, -141, -141, -141}; tbl[4].mask = 8'hFF;
    tbl[5].din = pack8('{-2048, 2047, -2048, 2047, -2048, 2047, -2048, 2047});
    tbl[5].exp = z;                                           tbl[5].mask = 8'h00;

    // Reset state
    repeat (2) @(negedge sys_clk);
    chk("rst ready", ready, 1);
    chk("rst data_en", data_en, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst x%0d", i), xo[i], 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    foreach (tbl[i]) run_vec(tbl[i].din, tbl[i].exp, tbl[i].mask, $sformatf("tbl%0d", i));

    // Busy/ignore: second start during CALC dropped, start in cycle 6 accepted
    start = 1'b1; din = tbl[0].din;
    for (int c = 1; c <= 12; c++) begin
      @(negedge sys_clk);
      start = 1'b0;
      chk($sformatf("busy data_en c%0d", c), data_en, (c == 5 || c == 11));
      if (c == 5 || c == 8) for (int i = 0; i < 8; i++) chk($sformatf("busy c%0d x%0d", c, i), xo[i], 283);
      if (c == 11) for (int i = 0; i < 8; i++) chk($sformatf("busy c11 x%0d", i), xo[i], -141);
      if (c == 3 || c == 6) begin start = 1'b1; din = tbl[4].din; end
    end

    // start held high: accepted every 6 cycles
    start = 1'b1; din = tbl[0].din;
    for (int c = 1; c <= 17; c++) begin
      @(negedge sys_clk);
      chk($sformatf("hold data_en c%0d", c), data_en, (c == 5 || c == 11 || c == 17));
    end
    start = 1'b0;
    @(negedge sys_clk);

    // Reset in cycle 2 of a vector
    start = 1'b1; din = tbl[1].din;
    @(negedge sys_clk); start = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst ready", ready, 1);
    chk("midrst data_en", data_en, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("midrst x%0d", i), xo[i], 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge sys_clk);
      chk("postrst data_en", data_en, 0);
      chk("postrst ready", ready, 1);
    end
    run_vec(tbl[0].din, tbl[0].exp, tbl[0].mask, "postrst dc");

    // Random regression, biased toward full-scale values
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 5))
          0:       v[k] = 2047;
          1:       v[k] = -2048;
          default: v[k] = int'($urandom_range(0, 4095)) - 2048;
        endcase
      end
      run_vec(pack8(v), z, 8'h00, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
